riscv_pipe_core: RTL and testbench

- Parametrised 5-stage (IF/ID/EX/MEM/WB) RV32I-subset integer core; successor to the first-generation pipelined core.
- Adds async reset, external instruction/data memory ports, data forwarding, load-use interlock, BEQ/BNE with flush, and a retire trace port.
- Sits between the top-level memory models and the test harness.

---
 rtl/riscv_pipe_core.sv | 188 ++++++++++++++++++
 tb/tb_riscv_pipe_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_core.sv
// Five-stage RV32I-subset pipeline (IF/ID/EX/MEM/WB) with BEQ/BNE flush and a retire trace port.
// Define RISCV_FORWARDING_EN for forwarding plus one-bubble load-use; otherwise ID stalls on EX/MEM hazards.
module riscv_pipe_core #(
   parameter int                XLEN     = 32,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic              dmem_we,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic              retire_valid,
   output logic [4:0]        retire_rd,
   output logic [XLEN-1:0]   retire_data
);
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int SH = $clog2(XLEN);
   localparam logic [6:0] OP_IMM = 7'b0010011, OP_REG = 7'b0110011, OP_LD = 7'b0000011,
                          OP_ST  = 7'b0100011, OP_BR  = 7'b1100011;

   function automatic logic supported(input logic [31:0] ir);
      supported = 1'b0;
      case (ir[6:0])
         OP_IMM:       supported = (ir[14:12] == 3'b001 || ir[14:12] == 3'b101)
                                   ? (ir[31:26] == 6'd0 && (XLEN == 64 || !ir[25]))
                                   : (ir[14:12] != 3'b011);
         OP_REG:       supported = (ir[31:25] == 7'h00 && ir[14:12] != 3'b011) ||
                                   (ir[31:25] == 7'h20 && ir[14:12] == 3'b000);
         OP_LD, OP_ST: supported = (ir[14:12] == 3'b010);
         OP_BR:        supported = (ir[14:13] == 2'b00);
         default:      supported = 1'b0;
      endcase
   endfunction

   function automatic logic writes(input logic [6:0] op, input logic [4:0] rd);
      return (op == OP_IMM || op == OP_REG || op == OP_LD) && rd != 5'd0;
   endfunction

   function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   logic [ADDR_W-1:0] pc, if_id_pc, id_ex_pc;
   logic [31:0]       if_id_ir, id_ex_ir;
   logic [XLEN-1:0]   id_ex_a, id_ex_b, ex_mem_alu, ex_mem_sd, mem_wb_val;
   logic              ex_mem_wen, ex_mem_ld, ex_mem_st, mem_wb_wen;
   logic [4:0]        ex_mem_rd, mem_wb_rd;
   logic [XLEN-1:0]   rf [1:31];

   // ID: unsupported encodings are turned into NOP here so later stages only look at opcodes.
   logic [31:0]     id_ir;
   logic [4:0]      id_rs1, id_rs2;
   logic            use1, use2, stall;
   logic [XLEN-1:0] id_a, id_b;
   assign id_ir  = supported(if_id_ir) ? if_id_ir : NOP;
   assign id_rs1 = id_ir[19:15];
   assign id_rs2 = id_ir[24:20];
   assign use1   = id_rs1 != 5'd0 && id_ir[6:0] != 7'b0010111 &&
                   (id_ir[6:0] == OP_IMM || id_ir[6:0] == OP_REG || id_ir[6:0] == OP_LD ||
                    id_ir[6:0] == OP_ST  || id_ir[6:0] == OP_BR);
   assign use2   = id_rs2 != 5'd0 &&
                   (id_ir[6:0] == OP_REG || id_ir[6:0] == OP_ST || id_ir[6:0] == OP_BR);

   always_comb begin
      id_a = '0;
      id_b = '0;
      if (id_rs1 != 5'd0) id_a = (mem_wb_wen && mem_wb_rd == id_rs1) ? mem_wb_val : rf[id_rs1];
      if (id_rs2 != 5'd0) id_b = (mem_wb_wen && mem_wb_rd == id_rs2) ? mem_wb_val : rf[id_rs2];
   end

`ifdef RISCV_FORWARDING_EN
   assign stall = id_ex_ir[6:0] == OP_LD && id_ex_ir[11:7] != 5'd0 &&
                  ((use1 && id_rs1 == id_ex_ir[11:7]) || (use2 && id_rs2 == id_ex_ir[11:7]));
`else
   assign stall = (writes(id_ex_ir[6:0], id_ex_ir[11:7]) &&
                   ((use1 && id_rs1 == id_ex_ir[11:7]) || (use2 && id_rs2 == id_ex_ir[11:7]))) ||
                  (ex_mem_wen && ((use1 && id_rs1 == ex_mem_rd) || (use2 && id_rs2 == ex_mem_rd)));
`endif

   // EX: operand selection, ALU and branch resolution.
   logic [6:0]        ex_op;
   logic [XLEN-1:0]   ex_a, ex_b, opb, alu;
   logic              taken;
   logic [ADDR_W-1:0] target;
   assign ex_op = id_ex_ir[6:0];

   always_comb begin
      ex_a = id_ex_a;
      ex_b = id_ex_b;
`ifdef RISCV_FORWARDING_EN
      if (mem_wb_wen && mem_wb_rd == id_ex_ir[19:15]) ex_a = mem_wb_val;
      if (mem_wb_wen && mem_wb_rd == id_ex_ir[24:20]) ex_b = mem_wb_val;
      if (ex_mem_wen && !ex_mem_ld && ex_mem_rd == id_ex_ir[19:15]) ex_a = ex_mem_alu;
      if (ex_mem_wen && !ex_mem_ld && ex_mem_rd == id_ex_ir[24:20]) ex_b = ex_mem_alu;
`endif
   end

   assign opb = (ex_op == OP_REG) ? ex_b
              : (ex_op == OP_ST)  ? sext({{20{id_ex_ir[31]}}, id_ex_ir[31:25], id_ex_ir[11:7]})
              :                     sext({{20{id_ex_ir[31]}}, id_ex_ir[31:20]});

   always_comb begin
      alu = ex_a + opb;
      if (ex_op == OP_IMM || ex_op == OP_REG) begin
         case (id_ex_ir[14:12])
            3'b000:  alu = (ex_op == OP_REG && id_ex_ir[30]) ? ex_a - opb : ex_a + opb;
            3'b001:  alu = ex_a << opb[SH-1:0];
            3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(opb)};
            3'b100:  alu = ex_a ^ opb;
            3'b101:  alu = ex_a >> opb[SH-1:0];
            3'b110:  alu = ex_a | opb;
            3'b111:  alu = ex_a & opb;
            default: alu = ex_a + opb;
         endcase
      end
   end

   assign taken  = ex_op == OP_BR && ((ex_a == ex_b) ^ id_ex_ir[12]);
   assign target = id_ex_pc + ADDR_W'($signed({{19{id_ex_ir[31]}}, id_ex_ir[31], id_ex_ir[7],
                                               id_ex_ir[30:25], id_ex_ir[11:8], 1'b0}));

   // A taken branch overrides a stall: both younger instructions are discarded anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         if_id_pc   <= '0;
         if_id_ir   <= NOP;
         id_ex_pc   <= '0;
         id_ex_ir   <= NOP;
         id_ex_a    <= '0;
         id_ex_b    <= '0;
         ex_mem_wen <= 1'b0;
         ex_mem_ld  <= 1'b0;
         ex_mem_st  <= 1'b0;
         ex_mem_rd  <= 5'd0;
         ex_mem_alu <= '0;
         ex_mem_sd  <= '0;
         mem_wb_wen <= 1'b0;
         mem_wb_rd  <= 5'd0;
         mem_wb_val <= '0;
      end else begin
         if (taken) begin
            pc       <= target;
            if_id_ir <= NOP;
            id_ex_ir <= NOP;
         end else if (stall) begin
            id_ex_ir <= NOP;
         end else begin
            pc       <= pc + ADDR_W'(4);
            if_id_pc <= pc;
            if_id_ir <= imem_rdata;
            id_ex_pc <= if_id_pc;
            id_ex_ir <= id_ir;
            id_ex_a  <= id_a;
            id_ex_b  <= id_b;
         end
         ex_mem_wen <= writes(ex_op, id_ex_ir[11:7]);
         ex_mem_rd  <= writes(ex_op, id_ex_ir[11:7]) ? id_ex_ir[11:7] : 5'd0;
         ex_mem_ld  <= ex_op == OP_LD;
         ex_mem_st  <= ex_op == OP_ST;
         ex_mem_alu <= alu;
         ex_mem_sd  <= ex_b;
         mem_wb_wen <= ex_mem_wen;
         mem_wb_rd  <= ex_mem_rd;
         mem_wb_val <= !ex_mem_wen ? '0 : (ex_mem_ld ? dmem_rdata : ex_mem_alu);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) rf[i] <= '0;
      end else if (mem_wb_wen) begin
         rf[mem_wb_rd] <= mem_wb_val;
      end
   end

   assign imem_addr    = pc;
   assign dmem_addr    = ADDR_W'(ex_mem_alu);
   assign dmem_wdata   = ex_mem_sd;
   assign dmem_we      = ex_mem_st;
   assign retire_valid = mem_wb_wen;
   assign retire_rd    = mem_wb_rd;
   assign retire_data  = mem_wb_val;
endmodule

// File: tb/tb_riscv_pipe_core.sv
// Directed bench for riscv_pipe_core: small programs in a local IMEM/DMEM, retire/store logs checked
// against hand-computed values and cycle numbers (cycle counted from reset release).
module tb_riscv_pipe_core;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, retire_data;
   logic        dmem_we, retire_valid;
   logic [4:0]  retire_rd;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   int          cyc;
   int          checks = 0;
   int          errors = 0;

   logic [4:0]  ret_rd_q[$];
   logic [31:0] ret_data_q[$];
   int          ret_cyc_q[$];
   logic [31:0] st_addr_q[$];
   logic [31:0] st_data_q[$];
   int          st_cyc_q[$];

`ifdef RISCV_FORWARDING_EN
   localparam int A_X2 = 5, A_X3 = 6, B_X5 = 6, C_ST = 4, D_X9 = 8, N_X7 = 6, N_X8 = 7, N_X9 = 8;
`else
   localparam int A_X2 = 7, A_X3 = 10, B_X5 = 7, C_ST = 6, D_X9 = 10, N_X7 = 8, N_X8 = 9, N_X9 = 10;
`endif

   riscv_pipe_core #(.XLEN(32), .ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_we      (dmem_we),
      .dmem_rdata   (dmem_rdata),
      .retire_valid (retire_valid),
      .retire_rd    (retire_rd),
      .retire_data  (retire_data)
   );

   always #5 clk = ~clk;

   assign imem_rdata = imem[imem_addr[7:2]];
   assign dmem_rdata = dmem[dmem_addr[7:2]];

   // DMEM is reloaded with its preset contents while reset is held.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
         dmem[16] <= 32'h0000_1234;
      end else if (dmem_we) begin
         dmem[dmem_addr[7:2]] <= dmem_wdata;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (rst_n && retire_valid) begin
         ret_rd_q.push_back(retire_rd);
         ret_data_q.push_back(retire_data);
         ret_cyc_q.push_back(cyc);
      end
      if (rst_n && dmem_we) begin
         st_addr_q.push_back(dmem_addr);
         st_data_q.push_back(dmem_wdata);
         st_cyc_q.push_back(cyc);
      end
   end

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
   endfunction
   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_lw(int imm, int rs1, int rd);
      return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
   endfunction
   function automatic logic [31:0] enc_sw(int imm, int rs2, int rs1);
      return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input int i, input int rd, input logic [31:0] data);
      if (i < ret_rd_q.size()) begin
         check({tag, "_rd"}, 32'(ret_rd_q[i]), 32'(rd));
         check({tag, "_data"}, ret_data_q[i], data);
      end else begin
         check({tag, "_missing"}, 32'(ret_rd_q.size()), 32'(i + 1));
      end
   endtask

   task automatic check_ret(input string tag, input int i, input int rd, input logic [31:0] data,
                            input int c);
      check_val(tag, i, rd, data);
      if (i < ret_cyc_q.size()) check({tag, "_cyc"}, 32'(ret_cyc_q[i]), 32'(c));
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
   endtask

   task automatic clear_logs();
      ret_rd_q.delete();
      ret_data_q.delete();
      ret_cyc_q.delete();
      st_addr_q.delete();
      st_data_q.delete();
      st_cyc_q.delete();
   endtask

   task automatic restart(input int ncyc);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
      repeat (ncyc) @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;

      // Dependency chain, interrupted by a mid-stream reset and then rerun.
      clear_imem();
      imem[0] = enc_i(5, 0, 0, 1);
      imem[1] = enc_r(0, 1, 1, 0, 2);
      imem[2] = enc_r(32, 1, 2, 0, 3);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_dmem_we", 32'(dmem_we), 32'h0);
      check("rst_retire_valid", 32'(retire_valid), 32'h0);
      check("rst_retire_rd", 32'(retire_rd), 32'h0);
      check("rst_retire_data", retire_data, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
      #1;
      check("rel_imem_addr", imem_addr, 32'h0);
      repeat (20) @(negedge clk);
      #1;
      check("dep_count", 32'(ret_rd_q.size()), 32'd3);
      check_ret("dep_x1", 0, 1, 32'd5, 4);
      check_ret("dep_x2", 1, 2, 32'd10, A_X2);
      check_ret("dep_x3", 2, 3, 32'd5, A_X3);

      // Load-use: LW x4,0x40(x0); ADDI x5,x4,1.
      clear_imem();
      imem[0] = enc_lw(32'h40, 0, 4);
      imem[1] = enc_i(1, 4, 0, 5);
      restart(20);
      check("ld_count", 32'(ret_rd_q.size()), 32'd2);
      check_ret("ld_x4", 0, 4, 32'h1234, 4);
      check_ret("ld_x5", 1, 5, 32'h1235, B_X5);

      // Store data forwarded from the preceding ADDI.
      clear_imem();
      imem[0] = enc_i(77, 0, 0, 6);
      imem[1] = enc_sw(8, 6, 0);
      restart(20);
      check_ret("st_x6", 0, 6, 32'd77, 4);
      check("st_count", 32'(st_addr_q.size()), 32'd1);
      if (st_addr_q.size() > 0) begin
         check("st_addr", st_addr_q[0], 32'd8);
         check("st_data", st_data_q[0], 32'd77);
         check("st_cyc", 32'(st_cyc_q[0]), 32'(C_ST));
      end
      check("st_mem", dmem[2], 32'd77);

      // Taken BEQ skips two instructions.
      clear_imem();
      imem[0] = enc_i(3, 0, 0, 1);
      imem[1] = enc_b(12, 1, 1, 0);
      imem[2] = enc_i(1, 0, 0, 7);
      imem[3] = enc_i(1, 0, 0, 8);
      imem[4] = enc_i(9, 0, 0, 9);
      restart(20);
      check("beq_count", 32'(ret_rd_q.size()), 32'd2);
      check_ret("beq_x1", 0, 1, 32'd3, 4);
      check_ret("beq_x9", 1, 9, 32'd9, D_X9);

      // Not-taken BNE falls through with no penalty.
      imem[1] = enc_b(12, 1, 1, 1);
      restart(20);
      check("bne_count", 32'(ret_rd_q.size()), 32'd4);
      check_ret("bne_x1", 0, 1, 32'd3, 4);
      check_ret("bne_x7", 1, 7, 32'd1, N_X7);
      check_ret("bne_x8", 2, 8, 32'd1, N_X8);
      check_ret("bne_x9", 3, 9, 32'd9, N_X9);

      // x0 discard, signed compares, shift-amount masking, unsupported opcode as NOP.
      clear_imem();
      imem[0] = enc_i(7, 0, 0, 0);
      imem[1] = enc_i(-1, 0, 0, 12);
      imem[2] = enc_i(33, 0, 0, 15);
      imem[3] = enc_r(0, 0, 12, 2, 13);
      imem[4] = enc_r(0, 15, 12, 5, 14);
      imem[5] = 32'h0000_087F;
      imem[6] = enc_i(32'h5A, 0, 4, 17);
      imem[7] = enc_i(0, 12, 2, 18);
      imem[8] = enc_r(0, 15, 15, 1, 19);
      restart(40);
      check("misc_count", 32'(ret_rd_q.size()), 32'd7);
      check_val("misc_x12", 0, 12, 32'hFFFF_FFFF);
      check_val("misc_x15", 1, 15, 32'd33);
      check_val("misc_x13", 2, 13, 32'd1);
      check_val("misc_x14", 3, 14, 32'h7FFF_FFFF);
      check_val("misc_x17", 4, 17, 32'h5A);
      check_val("misc_x18", 5, 18, 32'd1);
      check_val("misc_x19", 6, 19, 32'h42);
      check("misc_no_store", 32'(st_addr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
